// File: rtl/dtcore32_rvfi_pkg.sv
// Shared types for the RVFI retirement trace buffer.
// Optional memory fields are compiled in when RVFI_TRACE_MEM_EN is defined.
// The packet layout is fixed at RVFI_XLEN bits per data field.
package dtcore32_rvfi_pkg;

    localparam int RVFI_XLEN    = 32;
    localparam int RVFI_ORDER_W = 64;
    localparam int DROP_CNT_W   = 16;

    typedef struct packed {
        logic [RVFI_ORDER_W-1:0]  order;
        logic [31:0]              insn;
        logic                     trap;
        logic [RVFI_XLEN-1:0]     pc_rdata;
        logic [RVFI_XLEN-1:0]     pc_wdata;
        logic [4:0]               rd_addr;
        logic [RVFI_XLEN-1:0]     rd_wdata;
`ifdef RVFI_TRACE_MEM_EN
        logic [RVFI_XLEN-1:0]     mem_addr;
        logic [RVFI_XLEN/8-1:0]   mem_rmask;
        logic [RVFI_XLEN/8-1:0]   mem_wmask;
        logic [RVFI_XLEN-1:0]     mem_rdata;
        logic [RVFI_XLEN-1:0]     mem_wdata;
`endif
    } rvfi_pkt_t;

    localparam int RVFI_PKT_W = $bits(rvfi_pkt_t);

endpackage

// File: rtl/dt_sync_fifo.sv
// Generic single-clock FIFO with registered storage and head read from RAM.
// Latency: a word pushed into an empty FIFO is visible on rdata_o one cycle later.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module dt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    // Empty FIFO drives zeros so the head is clean after reset without resetting RAM.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers/occupancy; pointers wrap naturally.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port; contents are don't-care while unoccupied.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/rvfi_trace_fifo.sv
// RVFI retirement trace buffer with drop accounting and order-continuity checking.
// Latency: 1 cycle from retirement to out_pkt_o when empty; no input-to-output comb path.
// Backpressure: none toward the core; retirements arriving while full without a pop are dropped and counted.
// Memory fields/ports exist only when RVFI_TRACE_MEM_EN is defined. XLEN must equal RVFI_XLEN.
module rvfi_trace_fifo
    import dtcore32_rvfi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = RVFI_XLEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rvfi_valid,
    input  logic [RVFI_ORDER_W-1:0]   rvfi_order,
    input  logic [31:0]               rvfi_insn,
    input  logic                      rvfi_trap,
    input  logic [XLEN-1:0]           rvfi_pc_rdata,
    input  logic [XLEN-1:0]           rvfi_pc_wdata,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [XLEN-1:0]           rvfi_rd_wdata,
`ifdef RVFI_TRACE_MEM_EN
    input  logic [XLEN-1:0]           rvfi_mem_addr,
    input  logic [XLEN/8-1:0]         rvfi_mem_rmask,
    input  logic [XLEN/8-1:0]         rvfi_mem_wmask,
    input  logic [XLEN-1:0]           rvfi_mem_rdata,
    input  logic [XLEN-1:0]           rvfi_mem_wdata,
`endif
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output rvfi_pkt_t                 out_pkt_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [DROP_CNT_W-1:0]     drop_cnt_o,
    output logic                      order_err_o
);

    rvfi_pkt_t               in_pkt;
    logic [RVFI_PKT_W-1:0]   fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    accept;
    logic                    drop;

    logic                    overflow_q, overflow_d;
    logic                    order_err_q, order_err_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [RVFI_ORDER_W-1:0] exp_order_q, exp_order_d;
    logic                    first_q, first_d;

    // Pack the retirement port into the stored packet layout.
    always_comb begin
        in_pkt          = '0;
        in_pkt.order    = rvfi_order;
        in_pkt.insn     = rvfi_insn;
        in_pkt.trap     = rvfi_trap;
        in_pkt.pc_rdata = RVFI_XLEN'(rvfi_pc_rdata);
        in_pkt.pc_wdata = RVFI_XLEN'(rvfi_pc_wdata);
        in_pkt.rd_addr  = rvfi_rd_addr;
        in_pkt.rd_wdata = RVFI_XLEN'(rvfi_rd_wdata);
`ifdef RVFI_TRACE_MEM_EN
        in_pkt.mem_addr  = RVFI_XLEN'(rvfi_mem_addr);
        in_pkt.mem_rmask = (RVFI_XLEN/8)'(rvfi_mem_rmask);
        in_pkt.mem_wmask = (RVFI_XLEN/8)'(rvfi_mem_wmask);
        in_pkt.mem_rdata = RVFI_XLEN'(rvfi_mem_rdata);
        in_pkt.mem_wdata = RVFI_XLEN'(rvfi_mem_wdata);
`endif
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign out_valid_o = !fifo_empty;
    assign pop         = out_valid_o && out_ready_i;
    assign accept      = rvfi_valid && (!fifo_full || pop);
    assign drop        = rvfi_valid && fifo_full && !pop;

    dt_sync_fifo #(
        .WIDTH (RVFI_PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (in_pkt),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign out_pkt_o   = rvfi_pkt_t'(fifo_rdata);
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign order_err_o = order_err_q;

    // Sticky drop/order flags; only accepted packets advance the expected order,
    // so the first packet after a drop is reported as a discontinuity.
    always_comb begin
        overflow_d  = overflow_q;
        order_err_d = order_err_q;
        drop_cnt_d  = drop_cnt_q;
        exp_order_d = exp_order_q;
        first_d     = first_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
        if (accept) begin
            if (!first_q && (rvfi_order != exp_order_q)) begin
                order_err_d = 1'b1;
            end
            exp_order_d = rvfi_order + RVFI_ORDER_W'(1);
            first_d     = 1'b0;
        end
    end

    // Monitor state registers; first_q re-arms on reset so the order baseline restarts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            order_err_q <= 1'b0;
            drop_cnt_q  <= '0;
            exp_order_q <= '0;
            first_q     <= 1'b1;
        end else begin
            overflow_q  <= overflow_d;
            order_err_q <= order_err_d;
            drop_cnt_q  <= drop_cnt_d;
            exp_order_q <= exp_order_d;
            first_q     <= first_d;
        end
    end

endmodule

// File: doc/rvfi_trace_fifo.md
RVFI_TRACE_FIFO -- requirements
Module: rvfi_trace_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO entries, power of two, 2..256.
REQ-002 The block SHALL have parameter XLEN, default 32, RVFI data width.
REQ-003 The block SHALL have clk_i  input  1  sole clock, all logic rising-edge.
REQ-004 The block SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have rvfi_valid/order/insn/trap/pc_rdata/pc_wdata/rd_addr/rd_wdata  input  1/64/32/1/XLEN/XLEN/5/XLEN  core retirement port.
REQ-006 The block SHALL have rvfi_mem_addr/rmask/wmask/rdata/wdata  input  XLEN/XLEN/8/XLEN/8/XLEN  memory fields, present only under the macro in REQ-027.
REQ-007 The block SHALL have out_valid_o  output  1  head entry valid.
REQ-008 The block SHALL have out_ready_i  input  1  consumer accepts head.
REQ-009 The block SHALL have out_pkt_o  output  rvfi_pkt_t  head packet.
REQ-010 The block SHALL have count_o  output  $clog2(DEPTH)+1  occupancy.
REQ-011 The block SHALL have overflow_o  output  1  sticky, a retirement was dropped.
REQ-012 The block SHALL have drop_cnt_o  output  16  dropped retirements, saturating.
REQ-013 The block SHALL have order_err_o  output  1  sticky, non-consecutive rvfi_order accepted.

Function
REQ-014 Push SHALL occur on a cycle with rvfi_valid=1 and (count_o<DEPTH or pop in same cycle).
REQ-015 Pop SHALL occur on a cycle with out_valid_o=1 and out_ready_i=1; out_pkt_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-016 Pushed packet SHALL appear on out_pkt_o, out_valid_o=1, the cycle after the push edge when the FIFO was empty (1-cycle latency, no combinational in-to-out path).
REQ-017 Full with simultaneous push and pop: both SHALL occur, count_o unchanged, no drop.
REQ-018 Full, rvfi_valid=1, no pop: packet SHALL be discarded, overflow_o set, drop_cnt_o +1 saturating at 16'hFFFF.
REQ-019 Empty with simultaneous push and pop: not possible (out_valid_o=0); push alone SHALL occur.
REQ-020 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-021 count_o SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-022 Order check: the first accepted packet after reset SHALL set expected = order+1; each later accepted packet with order != expected SHALL set order_err_o; expected SHALL always become order+1 (64-bit wrap).
REQ-023 Dropped packets SHALL NOT update expected order; the next accepted packet after a drop SHALL therefore flag order_err_o.
REQ-024 overflow_o and order_err_o SHALL clear only on reset.

Reset
REQ-025 On rst_i=1, asynchronously: pointers, count_o, out_valid_o, overflow_o, order_err_o, drop_cnt_o SHALL be 0; out_pkt_o SHALL be 0; "first packet" flag SHALL be set.
REQ-026 Reset mid-operation SHALL discard all stored entries; storage RAM needs no reset.

Configuration
REQ-027 With RVFI_TRACE_MEM_EN defined, rvfi_pkt_t SHALL include mem_addr/rmask/wmask/rdata/wdata and the REQ-006 ports SHALL exist; without it those fields and ports SHALL be absent and all other behaviour identical.

Structure
REQ-028 Package dtcore32_rvfi_pkg SHALL hold rvfi_pkt_t (macro-conditional fields), RVFI_ORDER_W=64, DROP_CNT_W=16.
REQ-029 Storage/pointers SHALL be a sub-module dt_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); order check and drop logic SHALL live in rvfi_trace_fifo.

Verification
REQ-030 Reset, push order 0..3, out_ready_i=1 -> out_pkt_o.order 0,1,2,3 on consecutive cycles from cycle after first push; order_err_o=0.
REQ-031 DEPTH=16, out_ready_i=0, push 20 consecutive orders -> count_o=16, overflow_o=1, drop_cnt_o=4; drain returns orders 0..15.
REQ-032 Full, rvfi_valid=1 and out_ready_i=1 same cycle -> count_o stays 16, drop_cnt_o unchanged, new packet at tail.
REQ-033 Push orders 5,6,8 -> order_err_o rises the cycle after order 8 is accepted; stays 1 until rst_i.
REQ-034 Assert rst_i asynchronously (between edges) with 7 entries stored -> count_o=0, out_valid_o=0 immediately; next push order 100 gives no order_err_o.
REQ-035 Build with and without RVFI_TRACE_MEM_EN -> push with mem_wmask=4'hF, mem_wdata=32'hDEADBEEF returned intact when enabled; identical non-mem behaviour in both builds.
